vx_uop_expander: RTL and testbench

- Parametrised micro-op expander between the per-warp instruction buffer and issue.
- Expands one input instruction into 1..MAX_UOPS micro-ops and rewrites rd/rs1/rs2 per micro-op with per-instruction strides.
- Stalls the input until the last micro-op is accepted.
- Zero-bubble: micro-op 0 goes out in the same cycle the input becomes valid; back-to-back instructions have no idle cycle between them.

---
 rtl/vx_uop_expander.sv | 214 +++++++++++++++++++++
 tb/tb_vx_uop_expander.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_uop_expander.sv
// vx_uop_expander
//   Expands one instruction from the per-warp instruction buffer into
//   1..MAX_UOPS micro-ops for issue. Each micro-op's rd/rs1/rs2 fields are
//   computed as base + idx*step, wrapped modulo 2^REGW.
//
//   Micro-op 0 leaves in the same cycle the instruction arrives. The input is
//   held (in_ready low) until the last micro-op is accepted. Only the micro-op
//   index is stored here. The payload and register fields are taken from
//   in_* on every cycle, so upstream must hold in_* stable until in_ready.
//
//   Optional build macro UOP_EXPANDER_OUTREG_EN:
//     When defined, a 2-entry elastic buffer registers all out_* fields. This
//     adds one cycle of latency and keeps full throughput. out_ready then
//     drives only the buffer and never reaches in_ready combinationally.
//     When undefined, the outputs are combinational with zero added latency.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   in_valid/in_ready      instruction handshake (in_ready only on the last uop)
//   in_data                opaque payload, forwarded unchanged on out_data
//   in_count               micro-op count (0 -> 1, above MAX_UOPS -> MAX_UOPS)
//   in_rd/rs1/rs2          base register indices
//   in_*_step              per-micro-op register increments
//   out_valid/out_ready    micro-op handshake
//   out_data               copy of in_data
//   out_rd/rs1/rs2         rewritten register indices
//   out_uop_idx            micro-op index 0..count-1
//   out_first/out_last     first / last micro-op flags
//   busy                   expansion in progress (or buffer non-empty)
module vx_uop_expander #(
  parameter int DATAW    = 256,
  parameter int REGW     = 6,
  parameter int MAX_UOPS = 8,
  parameter int STEPW    = 3,
  parameter int CNTW     = $clog2(MAX_UOPS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  input  logic [CNTW-1:0]  in_count,
  input  logic [REGW-1:0]  in_rd,
  input  logic [REGW-1:0]  in_rs1,
  input  logic [REGW-1:0]  in_rs2,
  input  logic [STEPW-1:0] in_rd_step,
  input  logic [STEPW-1:0] in_rs1_step,
  input  logic [STEPW-1:0] in_rs2_step,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic [REGW-1:0]  out_rd,
  output logic [REGW-1:0]  out_rs1,
  output logic [REGW-1:0]  out_rs2,
  output logic [CNTW-1:0]  out_uop_idx,
  output logic             out_first,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  localparam int PW = DATAW + 3 * REGW + CNTW + 2;
  localparam int AW = REGW + CNTW + STEPW;

  state_t           state_reg, state_next;
  logic [CNTW-1:0]  idx_reg, idx_next;
  logic [CNTW-1:0]  cnt_eff;
  logic [CNTW-1:0]  cur_idx;
  logic             core_valid, core_ready, core_last;
  logic [REGW-1:0]  base_arr [3];
  logic [STEPW-1:0] step_arr [3];
  logic [REGW-1:0]  field_arr [3];
  logic [PW-1:0]    core_word;

  // The product is formed at full width, and only then truncated. This is
  // what makes the register fields wrap modulo 2^REGW.
  function automatic logic [REGW-1:0] uop_reg(input logic [REGW-1:0]  base,
                                              input logic [STEPW-1:0] step,
                                              input logic [CNTW-1:0]  idx);
    logic [AW-1:0] sum;
    sum = AW'(base) + AW'(idx) * AW'(step);
    return sum[REGW-1:0];
  endfunction

  always_comb begin
    if (in_count == '0)
      cnt_eff = CNTW'(1);
    else if (in_count > CNTW'(MAX_UOPS))
      cnt_eff = CNTW'(MAX_UOPS);
    else
      cnt_eff = in_count;
  end

  // In IDLE the micro-op shown is always micro-op 0 of the current input.
  assign cur_idx    = (state_reg == ACTIVE) ? idx_reg : '0;
  assign core_last  = (cur_idx == cnt_eff - CNTW'(1));
  assign core_valid = (state_reg == ACTIVE) || in_valid;

  assign base_arr[0] = in_rd;
  assign base_arr[1] = in_rs1;
  assign base_arr[2] = in_rs2;
  assign step_arr[0] = in_rd_step;
  assign step_arr[1] = in_rs1_step;
  assign step_arr[2] = in_rs2_step;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_field
      assign field_arr[gi] = uop_reg(base_arr[gi], step_arr[gi], cur_idx);
    end
  endgenerate

  assign core_word = {in_data, field_arr[0], field_arr[1], field_arr[2], cur_idx,
                      (cur_idx == '0), core_last};

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid && core_ready && !core_last) begin
          state_next = ACTIVE;
          idx_next   = CNTW'(1);
        end
      end
      ACTIVE: begin
        if (core_ready) begin
          if (core_last) begin
            state_next = IDLE;
            idx_next   = '0;
          end else begin
            idx_next   = idx_reg + CNTW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // FSM: outputs. The instruction is consumed only when its last micro-op
  // moves on. For a single-uop instruction this is a plain pass-through.
  always_comb begin
    in_ready = core_last && core_ready;
  end

`ifdef UOP_EXPANDER_OUTREG_EN
  logic [PW-1:0] fifo_mem [2];
  logic          wr_ptr_reg, rd_ptr_reg;
  logic [1:0]    count_reg;
  logic          push, pop;

  // The ready signal depends only on the buffer occupancy. This keeps
  // out_ready out of the in_ready path.
  assign core_ready = (count_reg != 2'd2);
  assign push       = core_valid && core_ready;
  assign pop        = out_valid && out_ready;
  assign out_valid  = (count_reg != 2'd0);

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= core_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push)
        wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)
        rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  assign {out_data, out_rd, out_rs1, out_rs2, out_uop_idx, out_first, out_last} =
         fifo_mem[rd_ptr_reg];
  assign busy = (state_reg == ACTIVE) || (count_reg != 2'd0);
`else
  assign core_ready = out_ready;
  assign out_valid  = core_valid;
  assign {out_data, out_rd, out_rs1, out_rs2, out_uop_idx, out_first, out_last} =
         core_word;
  assign busy = (state_reg == ACTIVE);
`endif

`ifndef SYNTHESIS
  // Only idx is stored here, so the held instruction must not change.
  a_in_stable: assert property (@(posedge clk) disable iff (reset)
    (in_valid && !in_ready) |=> (in_valid && $stable(in_data) && $stable(in_count) &&
      $stable(in_rd) && $stable(in_rs1) && $stable(in_rs2) && $stable(in_rd_step) &&
      $stable(in_rs1_step) && $stable(in_rs2_step)));
  a_active_valid: assert property (@(posedge clk) disable iff (reset)
    (state_reg == ACTIVE) |-> in_valid);
`endif

endmodule

// File: tb/tb_vx_uop_expander.sv
module tb_vx_uop_expander;
  localparam int DATAW = 256;
  localparam int REGW  = 6;
  localparam int MAXU  = 8;
  localparam int STEPW = 3;
  localparam int CNTW  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready;
  logic [DATAW-1:0] in_data;
  logic [CNTW-1:0]  in_count;
  logic [REGW-1:0]  in_rd, in_rs1, in_rs2;
  logic [STEPW-1:0] in_rd_step, in_rs1_step, in_rs2_step;
  logic             out_valid, out_ready;
  logic [DATAW-1:0] out_data;
  logic [REGW-1:0]  out_rd, out_rs1, out_rs2;
  logic [CNTW-1:0]  out_uop_idx;
  logic             out_first, out_last, busy;

  vx_uop_expander dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_count(in_count),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd_step(in_rd_step), .in_rs1_step(in_rs1_step), .in_rs2_step(in_rs2_step),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_uop_idx(out_uop_idx), .out_first(out_first), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATAW-1:0] data;
    int rd, rs1, rs2, idx;
    bit first, last;
  } uop_t;

  uop_t exp_q[$];
  int   acc_rd[$], acc_rs1[$], acc_idx[$];
  int   tests = 0, fails = 0;
  bit   in_hs = 0;
  int   ready_mode = 0;
  logic [31:0] ready_pat = '1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cnt_eff_f(input int c);
    return (c == 0) ? 1 : ((c > MAXU) ? MAXU : c);
  endfunction

  // Downstream ready generator. It updates 2 time units after the edge, after
  // the driver.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          out_ready = ready_pat[0];
          ready_pat = {1'b1, ready_pat[31:1]};
        end
      endcase
    end
  end

  // Compare process. On each falling edge it checks the DUT against the head
  // of the expected micro-op queue.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        in_hs = 0;
      end else if (exp_q.size() == 0) begin
        in_hs = 0;
        chk("idle_out_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
      end else begin
        uop_t h;
        h = exp_q[0];
        chk("out_valid", out_valid, 1);
        chk("out_rd", out_rd, h.rd);
        chk("out_rs1", out_rs1, h.rs1);
        chk("out_rs2", out_rs2, h.rs2);
        chk("out_uop_idx", out_uop_idx, h.idx);
        chk("out_first", out_first, h.first);
        chk("out_last", out_last, h.last);
        chk("in_ready", in_ready, out_ready && h.last);
        chk("busy", busy, h.idx != 0);
        tests++;
        if (out_data !== h.data) begin
          fails++;
          $display("FAIL out_data: got %h expected %h", out_data, h.data);
        end
        in_hs = in_valid && in_ready;
        if (out_valid && out_ready) begin
          acc_rd.push_back(int'(out_rd));
          acc_rs1.push_back(int'(out_rs1));
          acc_idx.push_back(int'(out_uop_idx));
          exp_q.pop_front();
        end
      end
    end
  end

  // Presents one instruction and queues its micro-ops in the model.
  task automatic present(input int cnt, input int rd, input int rs1, input int rs2,
                         input int srd, input int srs1, input int srs2);
    logic [DATAW-1:0] d;
    int n;
    for (int i = 0; i < DATAW / 32; i++) d[i*32 +: 32] = $urandom();
    in_data = d; in_count = CNTW'(cnt);
    in_rd = REGW'(rd); in_rs1 = REGW'(rs1); in_rs2 = REGW'(rs2);
    in_rd_step = STEPW'(srd); in_rs1_step = STEPW'(srs1); in_rs2_step = STEPW'(srs2);
    in_valid = 1'b1;
    n = cnt_eff_f(cnt);
    for (int k = 0; k < n; k++) begin
      uop_t u;
      u.data = d;
      u.rd  = (rd + k * srd) % 64;
      u.rs1 = (rs1 + k * srs1) % 64;
      u.rs2 = (rs2 + k * srs2) % 64;
      u.idx = k; u.first = (k == 0); u.last = (k == n - 1);
      exp_q.push_back(u);
    end
  endtask

  // Called 1 time unit after a rising edge. Returns 1 time unit after the
  // accepting edge, with in_valid low.
  task automatic send(input int cnt, input int rd, input int rs1, input int rs2,
                      input int srd, input int srs1, input int srs2, output int cycles);
    present(cnt, rd, rs1, rs2, srd, srs1, srs2);
    cycles = 0;
    do begin
      @(posedge clk);
      cycles++;
      if (cycles > 300) begin
        $display("FAIL handshake_timeout: got no in_ready expected in_ready within 300 cycles");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
      end
    end while (!in_hs);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic void clear_logs();
    acc_rd.delete(); acc_rs1.delete(); acc_idx.delete();
  endfunction

  initial begin
    int cyc, cyc2, bound;
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "global timeout");
  end

  initial begin
    int cyc, cyc2, bound;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_count = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_rd_step = '0; in_rs1_step = '0; in_rs2_step = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", in_ready, out_ready);
    @(posedge clk); #1;

    // Pass-through
    clear_logs();
    send(1, 5, 1, 2, 0, 0, 0, cyc);
    $display("[TB] pass-through: cycles=%0d rd=%0d", cyc, acc_rd[0]);
    chk("pt_cycles", cyc, 1);
    chk("pt_rd", acc_rd[0], 5);

    // Expansion
    clear_logs();
    send(4, 8, 3, 0, 2, 1, 0, cyc);
    $display("[TB] expansion: cycles=%0d uops=%0d", cyc, acc_rd.size());
    chk("exp_cycles", cyc, 4);
    chk("exp_uops", acc_rd.size(), 4);
    for (int i = 0; i < 4 && i < acc_rd.size(); i++) begin
      chk("exp_rd", acc_rd[i], 8 + 2 * i);
      chk("exp_rs1", acc_rs1[i], 3 + i);
      chk("exp_idx", acc_idx[i], i);
    end

    // Backpressure: out_ready is low for 3 cycles starting at cycle 2.
    clear_logs();
    ready_pat = 32'hFFFF_FFF1; ready_mode = 2;
    send(3, 10, 20, 30, 1, 2, 3, cyc);
    ready_mode = 0;
    $display("[TB] backpressure: cycles=%0d uops=%0d", cyc, acc_rd.size());
    chk("bp_cycles", cyc, 6);
    chk("bp_uops", acc_rd.size(), 3);

    // Count 0
    clear_logs();
    send(0, 7, 7, 7, 3, 3, 3, cyc);
    $display("[TB] count0: cycles=%0d uops=%0d", cyc, acc_rd.size());
    chk("c0_uops", acc_rd.size(), 1);
    chk("c0_cycles", cyc, 1);

    // Count 15 is clamped to 8.
    clear_logs();
    send(15, 0, 1, 2, 1, 1, 1, cyc);
    $display("[TB] count15: cycles=%0d uops=%0d", cyc, acc_rd.size());
    chk("c15_uops", acc_rd.size(), 8);
    chk("c15_cycles", cyc, 8);

    // Register wrap-around
    clear_logs();
    send(3, 62, 0, 0, 1, 0, 0, cyc);
    $display("[TB] wrap: rd=%0d,%0d,%0d", acc_rd[0], acc_rd[1], acc_rd[2]);
    chk("wrap_rd0", acc_rd[0], 62);
    chk("wrap_rd1", acc_rd[1], 63);
    chk("wrap_rd2", acc_rd[2], 0);

    // Back-to-back: the monitor flags any bubble.
    clear_logs();
    send(2, 1, 1, 1, 1, 1, 1, cyc);
    send(2, 9, 9, 9, 2, 2, 2, cyc2);
    $display("[TB] back-to-back: cycles=%0d+%0d uops=%0d", cyc, cyc2, acc_rd.size());
    chk("b2b_cycles", cyc + cyc2, 4);
    chk("b2b_uops", acc_rd.size(), 4);

    // Reset mid-expansion at idx=2
    clear_logs();
    present(5, 4, 4, 4, 1, 1, 1);
    bound = 0;
    do begin
      @(posedge clk);
      bound++;
    end while (acc_rd.size() < 2 && bound < 50);
    chk("rst_reached_idx2", acc_rd.size(), 2);
    #1;
    reset = 1'b1; in_valid = 1'b0; exp_q.delete();
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    $display("[TB] mid reset: busy=%0d idx=%0d", busy, out_uop_idx);
    chk("rst_busy", busy, 0);
    chk("rst_idx", out_uop_idx, 0);
    @(posedge clk); #1;
    send(1, 33, 0, 0, 0, 0, 0, cyc);
    $display("[TB] after reset: cycles=%0d", cyc);
    chk("rst_new_cycles", cyc, 1);

    // Randomized traffic
    ready_mode = 1;
    for (int n = 0; n < 150; n++) begin
      send($urandom_range(0, 15), $urandom_range(0, 63), $urandom_range(0, 63),
           $urandom_range(0, 63), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7), cyc);
      $display("[TB] random instr %0d: count=%0d cycles=%0d", n, in_count, cyc);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    ready_mode = 0;
    repeat (3) @(posedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
